// File: rtl/router_out_reader.sv
// Read-side drain engine for one router output FIFO: pops bytes, parses header/payload/parity,
// presents them over a valid/read handshake and flushes the FIFO on a stall timeout.
// Optional parity check is compiled in with ROUTER_RD_PARITY_CHK_EN.
module router_out_reader #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       fifo_soft_rst,
  output logic       vld_out,
  output logic [7:0] data_out,
  input  logic       read_out,
  output logic       sop,
  output logic       eop,
  output logic       pkt_done,
  output logic       parity_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic       inflight_q;
  logic       vld_q;
  logic       sop_q;
  logic       eop_q;
  logic       soft_rst_q;
  logic       pkt_done_q;
  logic [7:0] data_q;
  logic [7:0] stall_q;
  logic [5:0] len_q;
  logic [5:0] cnt_q;

  logic       xfer_s;
  logic       flush_s;
  logic       load_s;
  logic       pop_s;
  logic [5:0] cnt_inc_s;

  // Handshake, flush and pop decisions for the current cycle
  always_comb begin
    xfer_s    = vld_q && read_out;
    flush_s   = vld_q && !read_out && (stall_q == STALL_LAST);
    load_s    = inflight_q && !flush_s;
    cnt_inc_s = cnt_q + 6'd1;
    // no pop while held in reset or while the FIFO is being cleared
    pop_s     = !rst && !fifo_empty && !inflight_q && (!vld_q || read_out) &&
                !flush_s && !soft_rst_q;
  end

  // Packet FSM, output register, in-flight flag and stall timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      vld_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      soft_rst_q <= 1'b0;
      pkt_done_q <= 1'b0;
      data_q     <= 8'd0;
      stall_q    <= 8'd0;
      len_q      <= 6'd0;
      cnt_q      <= 6'd0;
    end else begin
      soft_rst_q <= flush_s;
      pkt_done_q <= xfer_s && eop_q;
      // a popped byte always returns next cycle, so in-flight lasts exactly one cycle
      inflight_q <= pop_s;
      if (flush_s || !vld_q || read_out) begin
        stall_q <= 8'd0;
      end else begin
        stall_q <= stall_q + 8'd1;
      end
      if (flush_s) begin
        vld_q   <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
        state_q <= IDLE;
      end else if (load_s) begin
        vld_q  <= 1'b1;
        data_q <= fifo_data;
        case (state_q)
          IDLE: begin
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            len_q   <= fifo_data[7:2];
            cnt_q   <= 6'd0;
            state_q <= (fifo_data[7:2] == 6'd0) ? PARITY : PAYLOAD;
          end
          PAYLOAD: begin
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s == len_q) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            sop_q   <= 1'b0;
            eop_q   <= 1'b1;
            state_q <= IDLE;
          end
          default: begin
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end else if (xfer_s) begin
        vld_q <= 1'b0;
        sop_q <= 1'b0;
        eop_q <= 1'b0;
      end
    end
  end

`ifdef ROUTER_RD_PARITY_CHK_EN
  logic [7:0] par_q;
  logic       perr_q;

  function automatic logic [7:0] fold_par(input logic is_hdr, input logic [7:0] acc,
                                          input logic [7:0] b);
    return is_hdr ? b : (acc ^ b);
  endfunction

  // Running parity over header and payload, checked when the parity byte is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q  <= 8'd0;
      perr_q <= 1'b0;
    end else begin
      perr_q <= xfer_s && eop_q && (par_q != data_q);
      if (load_s && (state_q != PARITY)) begin
        par_q <= fold_par(state_q == IDLE, par_q, fifo_data);
      end
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign fifo_rd_en    = pop_s;
  assign fifo_soft_rst = soft_rst_q;
  assign vld_out       = vld_q;
  assign data_out      = data_q;
  assign sop           = sop_q;
  assign eop           = eop_q;
  assign pkt_done      = pkt_done_q;

endmodule
